// File: rtl/card_cursor_board_if.sv
// Bundles the button, board-write and select handshake signals of card_cursor_board.
interface card_cursor_board_if;
    logic       BtnU;
    logic       BtnD;
    logic       BtnL;
    logic       BtnR;
    logic       BtnC;
    logic       WriteEnable;
    logic [3:0] dataLoc;
    logic [5:0] dataOut;
    logic       Ack;
    logic       Select;
    logic [3:0] CardSelectLoc;
    logic [5:0] CardSelectData;
    logic       Reject;

    modport master (
        output BtnU, BtnD, BtnL, BtnR, BtnC, WriteEnable, dataLoc, dataOut, Ack,
        input  Select, CardSelectLoc, CardSelectData, Reject
    );

    modport slave (
        input  BtnU, BtnD, BtnL, BtnR, BtnC, WriteEnable, dataLoc, dataOut, Ack,
        output Select, CardSelectLoc, CardSelectData, Reject
    );
endinterface

// File: rtl/card_cursor_board.sv
// 4x4 card board with a wrapping cursor and a Select/Ack handshake to gameplay_sm.
// Optional macro SELECT_TIMEOUT_EN abandons a PENDING select after 255 cycles without Ack.
module card_cursor_board #(
    parameter logic [3:0] CURSOR_RESET_LOC = 4'd0
) (
    input  logic               Clk,
    input  logic               Reset,
    card_cursor_board_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] loc_q, loc_d;
    logic       select_q, select_d;
    logic       reject_q, reject_d;
    logic [5:0] board_q [16];
    logic [5:0] board_d [16];
    logic [5:0] entry_s;
    logic [1:0] row_s;
    logic [1:0] col_s;

`ifdef SELECT_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    function automatic logic is_selectable(input logic [5:0] entry);
        return (entry[5] == 1'b0) && (entry[4] == 1'b0);
    endfunction

    assign row_s = loc_q[3:2];
    assign col_s = loc_q[1:0];
    // A write landing on the cursor this cycle decides selectability, not the stale entry.
    assign entry_s = (bus.WriteEnable && (bus.dataLoc == loc_q)) ? bus.dataOut : board_q[loc_q];

    // Board write port: active in every FSM state.
    always_comb begin
        board_d = board_q;
        if (bus.WriteEnable) begin
            board_d[bus.dataLoc] = bus.dataOut;
        end else begin
            board_d[bus.dataLoc] = board_q[bus.dataLoc];
        end
    end

    // Cursor movement, select FSM and reject pulse.
    always_comb begin
        state_d  = state_q;
        loc_d    = loc_q;
        reject_d = 1'b0;
`ifdef SELECT_TIMEOUT_EN
        cnt_d    = 8'd0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.BtnC) begin
                    if (is_selectable(entry_s)) begin
                        state_d = PENDING;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (bus.BtnU) begin
                    loc_d = {row_s - 2'd1, col_s};
                end else if (bus.BtnD) begin
                    loc_d = {row_s + 2'd1, col_s};
                end else if (bus.BtnL) begin
                    loc_d = {row_s, col_s - 2'd1};
                end else if (bus.BtnR) begin
                    loc_d = {row_s, col_s + 2'd1};
                end else begin
                    loc_d = loc_q;
                end
            end
            PENDING: begin
                if (bus.Ack) begin
                    state_d = RELEASE;
                end else begin
`ifdef SELECT_TIMEOUT_EN
                    if (cnt_q == 8'd254) begin
                        state_d  = IDLE;
                        reject_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`else
                    state_d = PENDING;
`endif
                end
            end
            RELEASE: begin
                if (!bus.Ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        select_d = (state_d == PENDING);
    end

    // State registers with asynchronous clear; writes during Reset are discarded.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            loc_q    <= CURSOR_RESET_LOC;
            select_q <= 1'b0;
            reject_q <= 1'b0;
            board_q  <= '{default: 6'd0};
`ifdef SELECT_TIMEOUT_EN
            cnt_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            loc_q    <= loc_d;
            select_q <= select_d;
            reject_q <= reject_d;
            board_q  <= board_d;
`ifdef SELECT_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.Select         = select_q;
    assign bus.Reject         = reject_q;
    assign bus.CardSelectLoc  = loc_q;
    assign bus.CardSelectData = board_q[loc_q];

endmodule

// File: doc/card_cursor_board.md
CARD_CURSOR_BOARD -- requirements
Module: card_cursor_board

Interface
REQ-001 Parameter: CURSOR_RESET_LOC, default 4'd0, cursor location loaded on reset (0..15).
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 BtnU/BtnD/BtnL/BtnR  input  1 each  single-cycle debounced move pulses.
REQ-005 BtnC  input  1  single-cycle debounced select pulse.
REQ-006 WriteEnable  input  1  board write strobe from gameplay_sm.
REQ-007 dataLoc  input  4  board write address from gameplay_sm.
REQ-008 dataOut  input  6  board write data from gameplay_sm.
REQ-009 Ack  input  1  gameplay_sm acknowledge of Select (level).
REQ-010 Select  output  1  selection request to gameplay_sm.
REQ-011 CardSelectLoc  output  4  current cursor location, row*4+col.
REQ-012 CardSelectData  output  6  board entry at CardSelectLoc.
REQ-013 Reject  output  1  one-cycle pulse: BtnC refused.

Function
REQ-014 Board SHALL be 16 x 6-bit registers; entry format: bit5 matched, bit4 face-up, bits3:0 card value.
REQ-015 When WriteEnable=1, board[dataLoc] SHALL take dataOut at the clock edge, in every FSM state.
REQ-016 CardSelectData SHALL be a combinational read of board[CardSelectLoc]; writes become visible the cycle after the edge.
REQ-017 Cursor is row=Loc[3:2], col=Loc[1:0]; U: row-1, D: row+1, L: col-1, R: col+1, all modulo 4 (wrap within row/column).
REQ-018 Cursor SHALL move only in IDLE; move pulses in PENDING or RELEASE SHALL be discarded, not queued.
REQ-019 Simultaneous pulses: priority C > U > D > L > R; at most one action per cycle.
REQ-020 FSM states: IDLE, PENDING, RELEASE (2-bit encoding).
REQ-021 IDLE: BtnC with selectable card -> PENDING; selectable means bit5=0 and bit4=0.
REQ-022 Selectability SHALL use write-first bypass: if WriteEnable=1 and dataLoc=CardSelectLoc in the same cycle, dataOut is checked instead of stored entry.
REQ-023 IDLE: BtnC with non-selectable card -> stay IDLE, Reject=1 for exactly the next cycle.
REQ-024 PENDING: Select=1, CardSelectLoc frozen; on Ack=1 -> RELEASE.
REQ-025 RELEASE: Select=0; on Ack=0 -> IDLE; BtnC ignored (no Reject).
REQ-026 Select SHALL be registered, asserted the cycle after the accepted BtnC edge, deasserted the cycle after Ack sampled high.
REQ-027 Ack high while in IDLE SHALL be ignored.

Reset
REQ-028 Reset SHALL immediately force: state IDLE, Select=0, Reject=0, cursor=CURSOR_RESET_LOC, all board entries 6'b000000.
REQ-029 Reset mid-handshake SHALL drop Select asynchronously; after release, a fresh BtnC is required.
REQ-030 WriteEnable during Reset SHALL have no effect.

Configuration
REQ-031 Macro SELECT_TIMEOUT_EN: when defined, an 8-bit counter SHALL run in PENDING; Ack absent for 255 consecutive PENDING cycles -> IDLE, Select=0, Reject pulse.
REQ-032 Counter SHALL clear on entry to PENDING and on reset.
REQ-033 Without SELECT_TIMEOUT_EN, PENDING SHALL wait for Ack indefinitely and no counter SHALL be synthesized.

Verification
REQ-034 Reset, then BtnL once -> CardSelectLoc=4'd3; BtnU once -> 4'd15; BtnD once -> 4'd3.
REQ-035 Write board[5]=6'h07, move cursor to 5, BtnC -> Select=1 next cycle, CardSelectData=6'h07; Ack=1 -> Select=0 next cycle; Ack=0 -> IDLE; BtnR in PENDING leaves Loc=5.
REQ-036 board[5]=6'h27 (matched), BtnC -> Select stays 0, Reject=1 for one cycle.
REQ-037 Same cycle BtnC and WriteEnable to cursor loc with dataOut=6'h13 -> refused (Reject=1); with dataOut=6'h03 -> accepted.
REQ-038 Assert Reset while Select=1 -> Select=0 within the same cycle, board reads 0, Loc=CURSOR_RESET_LOC.
REQ-039 With SELECT_TIMEOUT_EN, BtnC accepted and Ack held 0 -> Select=0 and Reject=1 after 255 PENDING cycles; without the macro Select remains 1 after 1000 cycles.
